// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: one full-width operation through a single 1-bit slice, LSB first.
// Optional perf counters (op_count, stall_cycles) enabled by defining ALU_BITSERIAL_SEQ_PERF_EN.
module alu_bitserial_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry_out,
    output logic             overflow,
    output logic             err,
    output logic             busy
`ifdef ALU_BITSERIAL_SEQ_PERF_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;

    logic slice_res;
    logic slice_cout;
    logic accept;
    logic in_reserved;
    logic op_reserved;
    logic op_arith;
    logic done;

    ALU_1b u_slice (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .res_o  (slice_res),
        .cout_o (slice_cout)
    );

    assign in_reserved = (op == 3'b001) || (op == 3'b111);
    assign op_reserved = (op_q == 3'b001) || (op_q == 3'b111);
    assign op_arith    = (op_q == 3'b010) || (op_q == 3'b011);
    assign done        = (state_q == DONE);
    assign accept      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    cnt_d   = '0;
                    carry_d = op[0];
                    cmsb_d  = 1'b0;
                    if (in_reserved) begin
                        res_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                res_d   = {slice_res, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_ff currently holds the carry into the MSB slice
                    cmsb_d  = carry_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
        end
    end

    // Flags are only meaningful while the result is being offered.
    assign in_ready  = reset_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = done;
    assign result    = res_q;
    assign zero      = done && !op_reserved && (res_q == '0);
    assign negative  = done && res_q[WIDTH-1];
    assign carry_out = done && op_arith && carry_q;
    assign overflow  = done && op_arith && (cmsb_q ^ carry_q);
    assign err       = done && op_reserved;

`ifdef ALU_BITSERIAL_SEQ_PERF_EN
    logic [31:0] op_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_valid && out_ready && (op_cnt_q != 32'hFFFF_FFFF)) begin
                op_cnt_q <= op_cnt_q + 32'd1;
            end
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign op_count     = op_cnt_q;
    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// 1-bit ALU slice: combinational, carry used only by add/subtract.
module ALU_1b (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] op_i,
    output logic       res_o,
    output logic       cout_o
);

    logic [1:0] sum;

    always_comb begin
        sum    = 2'b00;
        res_o  = 1'b0;
        cout_o = 1'b0;
        case (op_i)
            3'b000: res_o = b_i;
            3'b010: begin
                sum    = {1'b0, a_i} + {1'b0, b_i} + {1'b0, cin_i};
                res_o  = sum[0];
                cout_o = sum[1];
            end
            3'b011: begin
                sum    = {1'b0, a_i} + {1'b0, ~b_i} + {1'b0, cin_i};
                res_o  = sum[0];
                cout_o = sum[1];
            end
            3'b100:  res_o = a_i & b_i;
            3'b101:  res_o = a_i | b_i;
            3'b110:  res_o = a_i ^ b_i;
            default: res_o = 1'b0;
        endcase
    end

endmodule
